// File: rtl/shift_req_queue.sv
// shift_req_queue
//   Request-side buffer in front of the combinational shifter_32. Shift
//   requests {operand, amount, type} are queued in a DEPTH-entry FIFO. The
//   head entry is driven onto sh_* and the shifter result (sh_z) is captured
//   into a single registered output slot.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     request handshake; in_a/in_amt/in_type = request
//   sh_a/sh_amt/sh_type   head request to shifter_32 (from FIFO registers)
//   sh_z                  shifter_32 result, same cycle
//   out_valid/out_ready   result handshake; out_z result, out_zero (out_z==0)
//   count                 FIFO occupancy, 0..DEPTH
module shift_req_queue #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_a,
   input  logic [4:0]    in_amt,
   input  logic [1:0]    in_type,
   output logic [31:0]   sh_a,
   output logic [4:0]    sh_amt,
   output logic [1:0]    sh_type,
   input  logic [31:0]   sh_z,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_z,
   output logic          out_zero,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  amt;
      logic [1:0]  typ;
   } req_t;

   req_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          advance;
   req_t          head;

   // Full is judged on the registered count only, so a full FIFO refuses a
   // request even in a cycle where it also pops.
   assign in_ready = (count != CW'(DEPTH));
   assign push     = in_valid & in_ready;
   // The slot can take a new result when empty or when it is being drained.
   assign advance  = (count != '0) & (~out_valid | out_ready);

   // Storage is reset, so the head read is never X even when the FIFO is empty.
   assign head    = mem[rd_ptr];
   assign sh_a    = head.a;
   assign sh_amt  = head.amt;
   assign sh_type = head.typ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{a: in_a, amt: in_amt, typ: in_type};
         wr_ptr      <= wr_ptr + AW'(1);   // power-of-two depth: natural wrap
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_z     <= '0;
         out_zero  <= 1'b0;
      end else if (advance) begin
         out_z     <= sh_z;
         out_zero  <= (sh_z == '0);
         out_valid <= 1'b1;
         rd_ptr    <= rd_ptr + AW'(1);
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;                // data holds, only valid drops
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   count <= '0;
      else if (push & ~advance)  count <= count + CW'(1);
      else if (advance & ~push)  count <= count - CW'(1);
   end

endmodule

// File: tb/tb_shift_req_queue.sv
module tb_shift_req_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_a;
   logic [4:0]    in_amt;
   logic [1:0]    in_type;
   logic [31:0]   sh_a;
   logic [4:0]    sh_amt;
   logic [1:0]    sh_type;
   logic [31:0]   sh_z;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_z;
   logic          out_zero;
   logic [CW-1:0] count;

   typedef struct {
      logic [31:0] z;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // Behavioural stand-in for shifter_32.
   function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                             input logic [4:0]  amt,
                                             input logic [1:0]  t);
      logic [63:0] d;
      case (t)
         2'b00:   return a << amt;
         2'b01:   return a >> amt;
         2'b10:   return 32'($signed(a) >>> amt);
         default: begin
            d = {a, a} >> amt;
            return d[31:0];
         end
      endcase
   endfunction

   assign sh_z = ref_shift(sh_a, sh_amt, sh_type);

   shift_req_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_amt(in_amt), .in_type(in_type),
      .sh_a(sh_a), .sh_amt(sh_amt), .sh_type(sh_type), .sh_z(sh_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_zero(out_zero), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Output monitor: every accepted result is compared with the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (count > CW'(DEPTH)) begin
            bad++;
            $display("FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
         end
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out: got %h expected no result", out_z);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (out_z !== e.z || out_zero !== e.zero) begin
                  bad++;
                  $display("FAIL result: got z=%h zero=%b expected z=%h zero=%b",
                           out_z, out_zero, e.z, e.zero);
               end
            end
         end
      end
   end

   // Drive one request; expected result enters the scoreboard on acceptance.
   task automatic send(input logic [31:0] a, input logic [4:0] amt,
                       input logic [1:0] t, input logic [31:0] z);
      exp_t e;
      bit   done = 0;
      in_valid = 1'b1; in_a = a; in_amt = amt; in_type = t;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            e.z = z; e.zero = (z == 32'h0);
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
   endtask

   task automatic wait_empty(input string name);
      int c = 0;
      while ((sb.size() != 0 || out_valid) && c < 200) begin
         @(posedge clk); #1; c++;
      end
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
      check({name, "_count0"}, 32'(count), 32'd0);
   endtask

   initial begin
      bit fin;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_amt = '0; in_type = '0; out_ready = 1'b0;
      #2;
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_z", out_z, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sh_a", sh_a, 32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // Single request, latency two edges
      out_ready = 1'b1;
      send(32'h00000F00, 5'd1, 2'b00, 32'h00001E00);
      check("single_lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_z", out_z, 32'h00001E00);
      check("single_count", 32'(count), 32'd0);
      wait_empty("single");

      // Back-to-back types
      send(32'h00000F00, 5'd8, 2'b00, 32'h000F0000);
      send(32'h00000F00, 5'd8, 2'b01, 32'h0000000F);
      send(32'h00000F00, 5'd8, 2'b10, 32'h0000000F);
      send(32'h00000F00, 5'd8, 2'b11, 32'h0000000F);
      wait_empty("types");

      // Backpressure / full
      out_ready = 1'b0;
      send(32'd1, 5'd0, 2'b00, 32'd1);
      send(32'd2, 5'd1, 2'b00, 32'd4);
      send(32'd3, 5'd2, 2'b00, 32'd12);
      send(32'd4, 5'd3, 2'b00, 32'd32);
      send(32'd5, 5'd4, 2'b00, 32'd80);
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_stall_z", out_z, 32'd1);
      in_valid = 1'b1; in_a = 32'd6; in_amt = 5'd0; in_type = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("full_refused_count", 32'(count), 32'd4);
      check("full_hold_valid", 32'(out_valid), 32'd1);
      check("full_hold_z", out_z, 32'd1);
      out_ready = 1'b1;
      wait_empty("full");

      // Sign and zero
      send(32'h80000000, 5'd4, 2'b10, 32'hF8000000);
      send(32'h00000001, 5'd1, 2'b01, 32'h00000000);
      wait_empty("signzero");
      check("zero_flag", 32'(out_zero), 32'd1);

      // Continuous pushes with toggling out_ready, pointers wrap
      fin = 0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               logic [31:0] a;
               logic [4:0]  amt;
               logic [1:0]  t;
               a = 32'h8001_0000 | 32'(i * 32'h111);
               amt = 5'(i * 3);
               t = 2'(i);
               send(a, amt, t, ref_shift(a, amt, t));
            end
            fin = 1;
         end
         begin
            while (!fin) begin
               @(posedge clk); #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      wait_empty("wrap");

      // Reset mid-stream
      out_ready = 1'b0;
      send(32'h11, 5'd1, 2'b00, 32'h22);
      send(32'h12, 5'd1, 2'b00, 32'h24);
      send(32'h13, 5'd1, 2'b00, 32'h26);
      check("pre_rst_count", 32'(count), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_z", out_z, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      #3 rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_no_out", 32'(out_valid), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
